// File: rtl/pll_scan_reconfig.sv
// Scan-chain reconfiguration controller: streams one ROM image per frequency step
// into the selected MAX10 PLL, then issues configupdate, resets the PLL and waits for stable lock.
module pll_scan_reconfig #(
  parameter int unsigned NUM_PLL      = 2,
  parameter int unsigned FREQ_W       = 8,
  parameter int unsigned MAX_FREQ     = 96,
  parameter int unsigned DEFAULT_FREQ = 1,
  parameter int unsigned CHAIN_BITS   = 144,
  parameter int unsigned ROM_AW       = 14,
  parameter int unsigned RAMP_EN      = 1,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned TIMEOUT      = 65535,
  parameter int unsigned RETRIES      = 1,
  localparam int unsigned SEL_W       = (NUM_PLL > 1) ? $clog2(NUM_PLL) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        go_i,
  input  logic [SEL_W-1:0]            pll_sel_i,
  input  logic [FREQ_W-1:0]           req_freq_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o,
  output logic [NUM_PLL*FREQ_W-1:0]   cur_freq_o,
  output logic [ROM_AW-1:0]           rom_addr_o,
  input  logic                        rom_q_i,
  output logic                        scandata_o,
  output logic [NUM_PLL-1:0]          scanclkena_o,
  output logic [NUM_PLL-1:0]          configupdate_o,
  output logic [NUM_PLL-1:0]          areset_o,
  input  logic [NUM_PLL-1:0]          scandone_i,
  input  logic [NUM_PLL-1:0]          locked_i
);

  localparam int unsigned SELX_W = SEL_W + 1;
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned SH_W   = $clog2(CHAIN_BITS);
  localparam int unsigned LK_W   = $clog2(LOCK_STABLE + 1);
  localparam int unsigned ATT_W  = $clog2(RETRIES + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_ADDR, S_PRIME, S_SHIFT, S_UPDATE,
    S_WAIT_DONE, S_PRST, S_WAIT_LOCK, S_NEXT, S_FAIL
  } state_e;

  state_e                          state_q;
  logic [SEL_W-1:0]                sel_q;
  logic [FREQ_W-1:0]               tgt_q;
  logic [FREQ_W-1:0]               step_q;
  logic [NUM_PLL-1:0][FREQ_W-1:0]  cur_q;
  logic [WAIT_W-1:0]               wait_q;
  logic [SH_W-1:0]                 sh_cnt_q;
  logic [LK_W-1:0]                 lock_cnt_q;
  logic [ATT_W-1:0]                att_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            error_q;
  logic [ROM_AW-1:0]               rom_addr_q;
  logic [NUM_PLL-1:0]              scanclkena_q;
  logic [NUM_PLL-1:0]              configupdate_q;
  logic [NUM_PLL-1:0]              areset_q;
  logic [NUM_PLL-1:0]              lock_meta_q;
  logic [NUM_PLL-1:0]              lock_sync_q;

  logic [NUM_PLL-1:0]              onehot_d;
  logic [FREQ_W-1:0]               cur_sel_d;
  logic [ROM_AW-1:0]               base_d;
  logic                            req_bad_d;
  logic                            lock_d;

  // Next index on the way from frm to to: one step when ramping, otherwise straight there.
  function automatic logic [FREQ_W-1:0] step_toward(input logic [FREQ_W-1:0] frm,
                                                    input logic [FREQ_W-1:0] to);
    if (RAMP_EN == 0) return to;
    return (to > frm) ? frm + FREQ_W'(1) : frm - FREQ_W'(1);
  endfunction

  assign onehot_d  = NUM_PLL'(1) << sel_q;
  assign cur_sel_d = cur_q[sel_q];
  assign base_d    = ROM_AW'(ROM_AW'(step_q) * ROM_AW'(CHAIN_BITS) - ROM_AW'(1));
  assign req_bad_d = (tgt_q == '0) || (tgt_q > FREQ_W'(MAX_FREQ)) ||
                     (SELX_W'(sel_q) >= SELX_W'(NUM_PLL));
  assign lock_d    = lock_sync_q[sel_q];

  // Two-flop synchroniser for the asynchronous PLL lock indicators.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_meta_q <= '0;
      lock_sync_q <= '0;
    end else begin
      lock_meta_q <= locked_i;
      lock_sync_q <= lock_meta_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      sel_q          <= '0;
      tgt_q          <= '0;
      step_q         <= '0;
      for (int i = 0; i < int'(NUM_PLL); i++) cur_q[i] <= FREQ_W'(DEFAULT_FREQ);
      wait_q         <= '0;
      sh_cnt_q       <= '0;
      lock_cnt_q     <= '0;
      att_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      rom_addr_q     <= '0;
      scanclkena_q   <= '0;
      configupdate_q <= '0;
      areset_q       <= '0;
    end else begin
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      configupdate_q <= '0;
      areset_q       <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (go_i) begin
            sel_q   <= pll_sel_i;
            tgt_q   <= req_freq_i;
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (req_bad_d) begin
            state_q <= S_FAIL;
          end else if (tgt_q == cur_sel_d) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            step_q  <= step_toward(cur_sel_d, tgt_q);
            att_q   <= '0;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          rom_addr_q <= base_d;
          state_q    <= S_PRIME;
        end
        // ROM has one cycle of latency, so the first address is issued a cycle ahead of the shift.
        S_PRIME: begin
          rom_addr_q   <= rom_addr_q - ROM_AW'(1);
          sh_cnt_q     <= '0;
          scanclkena_q <= onehot_d;
          state_q      <= S_SHIFT;
        end
        S_SHIFT: begin
          if (sh_cnt_q == SH_W'(CHAIN_BITS - 1)) begin
            scanclkena_q   <= '0;
            configupdate_q <= onehot_d;
            wait_q         <= '0;
            state_q        <= S_UPDATE;
          end else begin
            sh_cnt_q <= sh_cnt_q + SH_W'(1);
            // Stop at the image's lowest word rather than stepping into the previous image.
            if (sh_cnt_q < SH_W'(CHAIN_BITS - 2)) rom_addr_q <= rom_addr_q - ROM_AW'(1);
          end
        end
        S_UPDATE: begin
          wait_q  <= '0;
          state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if ((scandone_i & onehot_d) != '0) begin
            areset_q <= onehot_d;
            state_q  <= S_PRST;
          end else if (wait_q == WAIT_W'(TIMEOUT)) begin
            if (att_q < ATT_W'(RETRIES)) begin
              att_q   <= att_q + ATT_W'(1);
              state_q <= S_ADDR;
            end else begin
              state_q <= S_FAIL;
            end
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_PRST: begin
          wait_q     <= '0;
          lock_cnt_q <= '0;
          state_q    <= S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_d && (lock_cnt_q == LK_W'(LOCK_STABLE - 1))) begin
            state_q <= S_NEXT;
          end else if (wait_q == WAIT_W'(TIMEOUT)) begin
            if (att_q < ATT_W'(RETRIES)) begin
              att_q   <= att_q + ATT_W'(1);
              state_q <= S_ADDR;
            end else begin
              state_q <= S_FAIL;
            end
          end else begin
            wait_q     <= wait_q + WAIT_W'(1);
            lock_cnt_q <= lock_d ? lock_cnt_q + LK_W'(1) : '0;
          end
        end
        S_NEXT: begin
          cur_q[sel_q] <= step_q;
          if (step_q == tgt_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            step_q  <= step_toward(step_q, tgt_q);
            att_q   <= '0;
            state_q <= S_ADDR;
          end
        end
        S_FAIL: begin
          error_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign cur_freq_o     = cur_q;
  assign rom_addr_o     = rom_addr_q;
  assign scandata_o     = rom_q_i;
  assign scanclkena_o   = scanclkena_q;
  assign configupdate_o = configupdate_q;
  assign areset_o       = areset_q;

endmodule
